burst_generator: RTL and testbench

//  Stimulus-side counterpart of the burst detector: synthesises a sample stream containing programmed bursts.

---
 rtl/burst_pkg.sv | 33 +++
 rtl/lfsr_noise.sv | 50 +++++
 rtl/burst_generator.sv | 240 ++++++++++++++++++++++++
 tb/tb_burst_generator.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : burst_pkg
// Description : Shared definitions for the burst generator and the burst
//               detector. Holds the default data/counter widths, the FSM
//               state encoding and the noise LFSR seed and feedback taps.
// Revision    : 1.0  initial release
// ============================================================================
package burst_pkg;

    // Default widths, shared with the detector so both ends agree on din.
    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned DEF_NB_W   = 8;
    localparam int unsigned DEF_LFSR_W = 16;

    // Noise LFSR: Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    // With a right-shifting register the feedback mask is the polynomial
    // divided by x, i.e. bits 15, 13, 12 and 10.
    localparam logic [15:0] C_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] C_LFSR_TAPS = 16'hB400;

    // Sequence state. The state register always describes the sample that
    // is currently on dout, so IDLE means "nothing being emitted".
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_BURST = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

endpackage : burst_pkg
`default_nettype wire

// File: rtl/lfsr_noise.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_noise
// Description : Galois LFSR used as the noise source of the burst generator.
//               Steps once per cycle with advance high, holds otherwise.
//               Only the low OUT_W bits are exported, as that is all the
//               noise adder consumes.
// Ports       : clock   - rising-edge clock
//               ss_n    - synchronous reset, active-high; reloads the seed
//               advance - step the register this cycle
//               state   - low OUT_W bits of the current register value
// Revision    : 1.0  initial release
// ============================================================================
module lfsr_noise
    import burst_pkg::*;
#(
    parameter int unsigned       LFSR_W = DEF_LFSR_W,
    parameter int unsigned       OUT_W  = DEF_WIDTH,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(C_LFSR_SEED),
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(C_LFSR_TAPS)
) (
    input  logic             clock,
    input  logic             ss_n,
    input  logic             advance,
    output logic [OUT_W-1:0] state
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Right shift; the bit falling out of position 0 folds the taps back in.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ TAPS;
        end
    end

    always_ff @(posedge clock) begin
        if (ss_n) begin
            lfsr_q <= SEED;
        end else if (advance) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q[OUT_W-1:0];

endmodule : lfsr_noise
`default_nettype wire

// File: rtl/burst_generator.sv
`default_nettype none
// ============================================================================
// Module      : burst_generator
// Description : Synthesises a sample stream for the burst detector: a
//               lead-in of background samples, then n_bursts bursts of a
//               programmed level and length separated by background gaps,
//               optionally with masked LFSR noise added (saturating).
// Ports       : clock        - rising-edge clock
//               ss_n         - synchronous reset, active-high
//               start        - one-cycle request, honoured only when idle
//               abort        - stop any sequence, wins over start
//               idle_level   - background sample value (lead-in and gaps)
//               burst_level  - sample value during a burst
//               burst_len    - samples per burst (0 behaves as 1)
//               gap_len      - samples in the lead-in and in each gap
//               n_bursts     - bursts per sequence (0 ignores start)
//               noise_en     - add masked LFSR noise to dout
//               noise_mask   - AND mask applied to the LFSR bits
//               dout         - sample to the detector
//               dout_valid   - high while a sequence is running
//               in_burst     - high while dout is a burst sample
//               busy         - high in any state but IDLE
//               done         - one-cycle pulse after the last burst sample
// Revision    : 1.0  initial release
// ============================================================================
module burst_generator
    import burst_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned NB_W   = DEF_NB_W,
    parameter int unsigned LFSR_W = DEF_LFSR_W
) (
    input  logic             clock,
    input  logic             ss_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] idle_level,
    input  logic [WIDTH-1:0] burst_level,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [CNT_W-1:0] gap_len,
    input  logic [NB_W-1:0]  n_bursts,
    input  logic             noise_en,
    input  logic [WIDTH-1:0] noise_mask,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             in_burst,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------
    // State, counters and latched configuration
    // ------------------------------------------------------------------
    state_e           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;        // samples left in phase, minus one
    logic [NB_W-1:0]  rem_q,        rem_d;        // bursts not yet finished
    logic [WIDTH-1:0] idle_lvl_q,   idle_lvl_d;
    logic [WIDTH-1:0] burst_lvl_q,  burst_lvl_d;
    logic [WIDTH-1:0] mask_q,       mask_d;
    logic [CNT_W-1:0] burst_last_q, burst_last_d; // burst length minus one
    logic [CNT_W-1:0] gap_len_q,    gap_len_d;

    // Registered outputs
    logic [WIDTH-1:0] dout_q,       dout_d;
    logic             valid_q,      valid_d;
    logic             in_burst_q,   in_burst_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;

    // Combinational helpers
    logic             w_start_ok;
    logic [CNT_W-1:0] w_burst_last_in;
    logic [WIDTH-1:0] w_lfsr_bits;
    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_noise;
    logic [WIDTH:0]   w_sum;

    // ------------------------------------------------------------------
    // Noise source. It steps on every edge that loads a valid sample, so
    // each emitted sample sees a fresh value and the register is frozen
    // for as long as the generator sits idle.
    // ------------------------------------------------------------------
    lfsr_noise #(
        .LFSR_W (LFSR_W),
        .OUT_W  (WIDTH)
    ) u_lfsr_noise (
        .clock   (clock),
        .ss_n    (ss_n),
        .advance (valid_d),
        .state   (w_lfsr_bits)
    );

    // ------------------------------------------------------------------
    // Next-state logic. The next state names the sample that will be on
    // dout after the edge, so the output registers are driven straight
    // from it and start reaches dout with a single cycle of latency.
    // ------------------------------------------------------------------
    always_comb begin
        w_start_ok      = (state_q == ST_IDLE) && start && !abort && (n_bursts != '0);
        w_burst_last_in = (burst_len == '0) ? '0 : (burst_len - CNT_W'(1));

        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        done_d       = 1'b0;
        idle_lvl_d   = idle_lvl_q;
        burst_lvl_d  = burst_lvl_q;
        mask_d       = mask_q;
        burst_last_d = burst_last_q;
        gap_len_d    = gap_len_q;

        case (state_q)
            ST_IDLE: begin
                if (w_start_ok) begin
                    // Configuration is captured here and held until the
                    // sequence ends; the first sample already uses it.
                    idle_lvl_d   = idle_level;
                    burst_lvl_d  = burst_level;
                    mask_d       = noise_mask;
                    burst_last_d = w_burst_last_in;
                    gap_len_d    = gap_len;
                    rem_d        = n_bursts;
                    if (gap_len == '0) begin
                        state_d = ST_BURST;
                        cnt_d   = w_burst_last_in;
                    end else begin
                        state_d = ST_LEAD;
                        cnt_d   = gap_len - CNT_W'(1);
                    end
                end
            end

            ST_LEAD, ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_BURST;
                    cnt_d   = burst_last_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_BURST: begin
                if (cnt_q == '0) begin
                    if (rem_q <= NB_W'(1)) begin
                        state_d = ST_IDLE;
                        rem_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        rem_d = rem_q - NB_W'(1);
                        if (gap_len_q == '0) begin
                            // Back-to-back bursts: stay in BURST so
                            // in_burst never drops between them.
                            cnt_d = burst_last_q;
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = gap_len_q - CNT_W'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rem_d   = '0;
            end
        endcase

        // Abort overrides everything, including a pending done pulse.
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rem_d   = '0;
            done_d  = 1'b0;
        end

        valid_d    = (state_d != ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        in_burst_d = (state_d == ST_BURST);

        // Saturating add: the extra sum bit is the overflow flag.
        w_level = in_burst_d ? burst_lvl_d : idle_lvl_d;
        w_noise = noise_en ? (w_lfsr_bits & mask_d) : '0;
        w_sum   = {1'b0, w_level} + {1'b0, w_noise};

        if (!valid_d) begin
            dout_d = '0;
        end else if (w_sum[WIDTH]) begin
            dout_d = '1;
        end else begin
            dout_d = w_sum[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (ss_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            idle_lvl_q   <= '0;
            burst_lvl_q  <= '0;
            mask_q       <= '0;
            burst_last_q <= '0;
            gap_len_q    <= '0;
            dout_q       <= '0;
            valid_q      <= 1'b0;
            in_burst_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            idle_lvl_q   <= idle_lvl_d;
            burst_lvl_q  <= burst_lvl_d;
            mask_q       <= mask_d;
            burst_last_q <= burst_last_d;
            gap_len_q    <= gap_len_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            in_burst_q   <= in_burst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign in_burst   = in_burst_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule : burst_generator
`default_nettype wire

// File: tb/tb_burst_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_generator
// Description : Self-checking bench for burst_generator. A reference model
//               expands each accepted start into a queue of expected
//               samples and tracks the noise LFSR as polynomial division.
// Revision    : 1.0  initial release
// ============================================================================
module tb_burst_generator;

    logic        clk = 1'b0;
    logic        ss_n;
    logic        start;
    logic        abort;
    logic [7:0]  idle_level;
    logic [7:0]  burst_level;
    logic [15:0] burst_len;
    logic [15:0] gap_len;
    logic [7:0]  n_bursts;
    logic        noise_en;
    logic [7:0]  noise_mask;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        in_burst;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    burst_generator #(
        .WIDTH  (8),
        .CNT_W  (16),
        .NB_W   (8),
        .LFSR_W (16)
    ) dut (
        .clock       (clk),
        .ss_n        (ss_n),
        .start       (start),
        .abort       (abort),
        .idle_level  (idle_level),
        .burst_level (burst_level),
        .burst_len   (burst_len),
        .gap_len     (gap_len),
        .n_bursts    (n_bursts),
        .noise_en    (noise_en),
        .noise_mask  (noise_mask),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .in_burst    (in_burst),
        .busy        (busy),
        .done        (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        bit         valid;
        bit         ib;
        bit         dn;
        logic [7:0] lvl;
        logic [7:0] mask;
    } exp_t;

    exp_t        q[$];
    bit          m_idle = 1'b1;
    logic [15:0] m_lfsr = 16'hACE1;

    // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [16:0] POLY = 17'h16801;

    // Multiply the field element by x^-1: add the polynomial when odd,
    // then divide by x.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [16:0] t;
        t = {1'b0, s};
        if (s[0]) t = t ^ POLY;
        return t[16:1];
    endfunction

    task automatic plan_sequence();
        int   blen;
        exp_t g;
        exp_t b;
        exp_t d;
        blen = (burst_len == 16'd0) ? 1 : int'(burst_len);
        g = '{valid: 1'b1, ib: 1'b0, dn: 1'b0, lvl: idle_level,  mask: noise_mask};
        b = '{valid: 1'b1, ib: 1'b1, dn: 1'b0, lvl: burst_level, mask: noise_mask};
        d = '{valid: 1'b0, ib: 1'b0, dn: 1'b1, lvl: 8'd0,        mask: 8'd0};
        for (int k = 0; k < int'(n_bursts); k++) begin
            for (int j = 0; j < int'(gap_len); j++) q.push_back(g);
            for (int j = 0; j < blen; j++) q.push_back(b);
        end
        q.push_back(d);
    endtask

    // Apply start/abort for one edge, predict, and compare all outputs.
    task automatic cycle(input bit s, input bit a);
        exp_t       e;
        logic [8:0] sum;
        logic [7:0] exp_dout;
        start = s;
        abort = a;
        e = '{valid: 1'b0, ib: 1'b0, dn: 1'b0, lvl: 8'd0, mask: 8'd0};
        if (a) begin
            q.delete();
        end else begin
            if (m_idle && s && n_bursts != 8'd0) plan_sequence();
            if (q.size() > 0) e = q.pop_front();
        end
        exp_dout = 8'd0;
        if (e.valid) begin
            sum = {1'b0, e.lvl} + (noise_en ? {1'b0, m_lfsr[7:0] & e.mask} : 9'd0);
            exp_dout = (sum > 9'd255) ? 8'd255 : sum[7:0];
            m_lfsr = lfsr_next(m_lfsr);
        end
        m_idle = !e.valid;
        @(posedge clk);
        #1;
        chk("dout",       32'(dout),       32'(exp_dout));
        chk("dout_valid", 32'(dout_valid), 32'(e.valid));
        chk("in_burst",   32'(in_burst),   32'(e.ib));
        chk("busy",       32'(busy),       32'(e.valid));
        chk("done",       32'(done),       32'(e.dn));
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run_to_idle();
        int guard;
        guard = 0;
        while (!(m_idle && q.size() == 0) && guard < 200) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
        chk("idle_timeout", 32'(guard < 200), 32'd1);
    endtask

    task automatic set_cfg(input logic [7:0] il, input logic [7:0] bl, input logic [15:0] blen,
                           input logic [15:0] gl, input logic [7:0] nb, input logic ne,
                           input logic [7:0] nm);
        idle_level  = il;
        burst_level = bl;
        burst_len   = blen;
        gap_len     = gl;
        n_bursts    = nb;
        noise_en    = ne;
        noise_mask  = nm;
    endtask

    // Directed vector table for the basic sequence
    typedef struct {
        bit         s;
        logic [7:0] d;
        bit         v;
        bit         ib;
        bit         bz;
        bit         dn;
    } vec_t;

    vec_t tbl[16];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int ib_cnt;
        int dn_cnt;
        int smp_cnt;
        int win[$];
        int wsum;
        bit det;
        bit det_prev;
        int det_rises;

        // idle=2, burst=50, len=4, gap=3, two bursts
        tbl[0]  = '{1'b1, 8'd2,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 8'd2,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 8'd2,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'd2,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 8'd2,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 8'd2,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b0};

        // ---------------- reset ----------------
        ss_n  = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(8'd7, 8'd9, 16'd3, 16'd2, 8'd1, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        start = 1'b1;  // must be ignored under reset
        @(posedge clk);
        #1;
        chk("rst_dout",  32'(dout),       32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_ib",    32'(in_burst),   32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_done",  32'(done),       32'd0);
        start = 1'b0;
        ss_n  = 1'b0;

        // ---------------- 1: basic sequence from table ----------------
        set_cfg(8'd2, 8'd50, 16'd4, 16'd3, 8'd2, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].s, 1'b0);
            chk($sformatf("t1[%0d].dout", i),  32'(dout),       32'(tbl[i].d));
            chk($sformatf("t1[%0d].valid", i), 32'(dout_valid), 32'(tbl[i].v));
            chk($sformatf("t1[%0d].ib", i),    32'(in_burst),   32'(tbl[i].ib));
            chk($sformatf("t1[%0d].busy", i),  32'(busy),       32'(tbl[i].bz));
            chk($sformatf("t1[%0d].done", i),  32'(done),       32'(tbl[i].dn));
        end
        run_to_idle();

        // ---------------- 2: gap 0, bursts back to back ----------------
        set_cfg(8'd2, 8'd50, 16'd4, 16'd0, 8'd3, 1'b0, 8'h00);
        ib_cnt = 0;
        dn_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(i == 0, 1'b0);
            if (in_burst) ib_cnt++;
            if (done) dn_cnt++;
            if (i < 12) begin
                chk("t2_ib_held", 32'(in_burst), 32'd1);
                chk("t2_dout",    32'(dout),     32'd50);
            end
        end
        chk("t2_ib_count",   32'(ib_cnt), 32'd12);
        chk("t2_done_count", 32'(dn_cnt), 32'd1);
        run_to_idle();

        // ---------------- 3: abort on 2nd burst sample ----------------
        set_cfg(8'd2, 8'd50, 16'd4, 16'd3, 8'd2, 1'b0, 8'h00);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
        chk("t3_second_burst", 32'(in_burst), 32'd1);
        cycle(1'b0, 1'b1);
        chk("t3_abort_dout", 32'(dout), 32'd0);
        chk("t3_abort_busy", 32'(busy), 32'd0);
        chk("t3_abort_done", 32'(done), 32'd0);
        cycle(1'b1, 1'b0);
        chk("t3_restart_busy", 32'(busy), 32'd1);
        chk("t3_restart_dout", 32'(dout), 32'd2);
        run_to_idle();
        // abort together with start in idle
        cycle(1'b1, 1'b1);
        chk("t3_abort_start_busy", 32'(busy), 32'd0);

        // ---------------- 4: zero bursts, start while busy ----------------
        set_cfg(8'd2, 8'd50, 16'd4, 16'd3, 8'd0, 1'b0, 8'h00);
        dn_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(i == 0, 1'b0);
            chk("t4_nb0_busy", 32'(busy), 32'd0);
            if (done) dn_cnt++;
        end
        chk("t4_nb0_done", 32'(dn_cnt), 32'd0);
        set_cfg(8'd2, 8'd50, 16'd4, 16'd3, 8'd2, 1'b0, 8'h00);
        cycle(1'b1, 1'b0);
        smp_cnt = 1;
        dn_cnt  = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) set_cfg(8'd77, 8'd99, 16'd9, 16'd1, 8'd5, 1'b0, 8'h00);
            cycle(i == 4 || i == 8, 1'b0);
            if (dout_valid) smp_cnt++;
            if (done) dn_cnt++;
        end
        chk("t4_samples", 32'(smp_cnt), 32'd14);
        chk("t4_dones",   32'(dn_cnt),  32'd1);
        run_to_idle();

        // ---------------- 5: saturating noise, LFSR frozen in idle ----------------
        for (int r = 0; r < 2; r++) begin
            set_cfg(8'd5, 8'd250, 16'd6, 16'd2, 8'd3, 1'b1, 8'h0F);
            cycle(1'b1, 1'b0);
            for (int i = 0; i < 30; i++) begin
                cycle(1'b0, 1'b0);
                if (in_burst) chk("t5_sat_range", 32'(dout >= 8'd250), 32'd1);
            end
            run_to_idle();
            for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0);
        end

        // ---------------- 6: stream seen by a windowed detector ----------------
        set_cfg(8'd10, 8'd0, 16'd8, 16'd8, 8'd4, 1'b0, 8'h00);
        det_prev  = 1'b0;
        det_rises = 0;
        for (int i = 0; i < 70; i++) begin
            cycle(i == 0, 1'b0);
            if (dout_valid) begin
                win.push_back(int'(dout));
                if (win.size() > 8) void'(win.pop_front());
            end
            wsum = 0;
            foreach (win[k]) wsum += win[k];
            det = (win.size() == 8) && (wsum < 20);
            if (det && !det_prev) det_rises++;
            det_prev = det;
        end
        chk("t6_detections", 32'(det_rises), 32'd4);
        run_to_idle();

        // ---------------- randomized ----------------
        for (int i = 0; i < 2500; i++) begin
            bit s;
            bit a;
            s = 1'b0;
            a = 1'b0;
            if (m_idle) begin
                if ($urandom_range(0, 3) == 0) begin
                    set_cfg(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                            16'($urandom_range(0, 5)), 16'($urandom_range(0, 4)),
                            8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                            8'($urandom_range(0, 255)));
                    s = 1'b1;
                end
                a = ($urandom_range(0, 31) == 0);
            end else begin
                if ($urandom_range(0, 7) == 0)
                    set_cfg(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                            16'($urandom_range(0, 5)), 16'($urandom_range(0, 4)),
                            8'($urandom_range(0, 3)), noise_en,
                            8'($urandom_range(0, 255)));
                if ($urandom_range(0, 9) == 0) noise_en = ~noise_en;
                s = ($urandom_range(0, 15) == 0);
                a = ($urandom_range(0, 39) == 0);
            end
            cycle(s, a);
        end
        run_to_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_burst_generator
`default_nettype wire
